// File: rtl/sync_ram_sdp_if.sv
// Bus bundle for the simple-dual-port RAM: write port, read port and status.
// The master side issues requests; the slave side is the RAM.
interface sync_ram_sdp_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
);
   localparam int unsigned NB = DATA_WIDTH / 8;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]         wr_be;
   logic                  wr_par_flip;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_par_err;
   logic                  busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, wr_par_flip, rd_en, rd_addr,
      input  rd_data, rd_valid, rd_par_err, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, wr_par_flip, rd_en, rd_addr,
      output rd_data, rd_valid, rd_par_err, busy
   );
endinterface

// File: rtl/sync_ram_sdp.sv
// Simple-dual-port synchronous RAM: byte-enabled write, registered read, selectable
// read-during-write, optional post-reset clear sweep. Define SYNC_RAM_PARITY_EN for per-byte parity.
module sync_ram_sdp #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned RDW_MODE       = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            rst,
   sync_ram_sdp_if.slave   bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned NB    = DATA_WIDTH / 8;

   generate
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
         $error("sync_ram_sdp: DATA_WIDTH must be a multiple of 8");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;
   logic                  busy_q, busy_nxt;

   // Muxed write port: either the clear sweep or a user write
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NB-1:0]         mem_wbe;
   logic                  mem_wflip;
   logic                  rd_fire;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DATA_WIDTH-1:0] rd_old, rd_merged, rd_word;
   logic                  collide;
   logic                  rd_err_nxt;

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  rd_par_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_addr <= '0;
         busy_q   <= (CLEAR_ON_RESET != 0);
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         busy_q   <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      busy_nxt     = busy_q;
      mem_we       = 1'b0;
      mem_waddr    = bus.wr_addr;
      mem_wdata    = bus.wr_data;
      mem_wbe      = bus.wr_be;
      mem_wflip    = bus.wr_par_flip;
      rd_fire      = 1'b0;
      case (state)
         ST_CLEAR: begin
            mem_we       = 1'b1;
            mem_waddr    = clr_addr;
            mem_wdata    = '0;
            mem_wbe      = '1;
            mem_wflip    = 1'b0;
            clr_addr_nxt = ADDR_WIDTH'(clr_addr + 1'b1);
            if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
               state_nxt = ST_READY;
               busy_nxt  = 1'b0;
            end
         end
         ST_READY: begin
            mem_we  = bus.wr_en;
            rd_fire = bus.rd_en;
         end
         default: begin
            state_nxt = ST_READY;
            busy_nxt  = 1'b0;
         end
      endcase
      // Reset edges never touch the array or the read port
      if (rst) begin
         mem_we  = 1'b0;
         rd_fire = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // Read-during-write: merged word is the value the array will hold after this edge
   assign collide = mem_we && (mem_waddr == bus.rd_addr);

   always_comb begin
      rd_old    = mem[bus.rd_addr];
      rd_merged = rd_old;
      for (int i = 0; i < int'(NB); i++) begin
         if (collide && mem_wbe[i]) rd_merged[8*i +: 8] = mem_wdata[8*i +: 8];
      end
      rd_word = (RDW_MODE != 0) ? rd_merged : rd_old;
   end

`ifdef SYNC_RAM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] wr_par, rd_par_word, rd_par_calc;

   // Even parity per byte; byte 0 may be deliberately corrupted on write
   always_comb begin
      wr_par      = '0;
      rd_par_calc = '0;
      rd_par_word = par_mem[bus.rd_addr];
      for (int i = 0; i < int'(NB); i++) begin
         wr_par[i] = (^mem_wdata[8*i +: 8]) ^ ((i == 0) ? mem_wflip : 1'b0);
         if ((RDW_MODE != 0) && collide && mem_wbe[i]) rd_par_word[i] = wr_par[i];
         rd_par_calc[i] = ^rd_word[8*i +: 8];
      end
      rd_err_nxt = |(rd_par_calc ^ rd_par_word);
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (mem_wbe[i]) par_mem[mem_waddr][i] <= wr_par[i];
         end
      end
   end
`else
   logic unused_par_flip;
   assign unused_par_flip = mem_wflip;
   assign rd_err_nxt      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_par_err_q <= 1'b0;
      end else begin
         rd_valid_q   <= rd_fire;
         rd_par_err_q <= rd_fire & rd_err_nxt;
         if (rd_fire) rd_data_q <= rd_word;
      end
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_par_err = rd_par_err_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sync_ram_sdp.sv
// Self-checking bench for sync_ram_sdp: old-data and new-data instances driven in parallel
// against an array-based reference model.
module tb_sync_ram_sdp;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
`ifdef SYNC_RAM_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          wr_par_flip;
   logic          rd_en;
   logic [AW-1:0] rd_addr;

   sync_ram_sdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   sync_ram_sdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.wr_en = wr_en;     assign bus1.wr_en = wr_en;
   assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
   assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
   assign bus0.wr_be = wr_be;     assign bus1.wr_be = wr_be;
   assign bus0.wr_par_flip = wr_par_flip;
   assign bus1.wr_par_flip = wr_par_flip;
   assign bus0.rd_en = rd_en;     assign bus1.rd_en = rd_en;
   assign bus0.rd_addr = rd_addr; assign bus1.rd_addr = rd_addr;

   sync_ram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));
   sync_ram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference model: word array, per-address "byte 0 parity corrupted" flag, sweep countdown
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_bad [DEPTH];
   int            sweep_left = 0;
   logic [DW-1:0] exp_d0 = '0, exp_d1 = '0;
   bit            exp_v = 0, exp_e0 = 0, exp_e1 = 0, exp_busy = 0;

   task automatic idle_inputs();
      wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0; wr_par_flip = 0;
      rd_en = 0; rd_addr = '0;
   endtask

   // Apply the current inputs to the model, then advance one clock and settle
   task automatic cycle();
      logic [DW-1:0] nw;
      bit            nbad;
      if (rst) begin
         sweep_left = DEPTH;
         exp_v = 0; exp_d0 = '0; exp_d1 = '0; exp_e0 = 0; exp_e1 = 0;
      end else if (sweep_left > 0) begin
         m_mem[DEPTH - sweep_left] = '0;
         m_bad[DEPTH - sweep_left] = 0;
         sweep_left--;
         exp_v = 0; exp_e0 = 0; exp_e1 = 0;
      end else begin
         nw = m_mem[wr_addr];
         for (int b = 0; b < 4; b++) if (wr_be[b]) nw[8*b +: 8] = wr_data[8*b +: 8];
         nbad = wr_be[0] ? wr_par_flip : m_bad[wr_addr];
         if (rd_en) begin
            exp_v  = 1;
            exp_d0 = m_mem[rd_addr];
            exp_e0 = m_bad[rd_addr];
            exp_d1 = (wr_en && wr_addr == rd_addr) ? nw : m_mem[rd_addr];
            exp_e1 = (wr_en && wr_addr == rd_addr) ? nbad : m_bad[rd_addr];
         end else begin
            exp_v = 0; exp_e0 = 0; exp_e1 = 0;
         end
         if (wr_en) begin
            m_mem[wr_addr] = nw;
            m_bad[wr_addr] = nbad;
         end
      end
      exp_busy = (sweep_left > 0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int cnt;
      idle_inputs();
      rst = 1;
      cycle(); cycle();
      n_vec++; if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b/%b expected 0", bus0.rd_valid, bus1.rd_valid); end
      n_vec++; if (bus0.rd_data !== '0 || bus1.rd_data !== '0) begin
         n_err++; $display("FAIL reset_data: got %h/%h expected 0", bus0.rd_data, bus1.rd_data); end
      n_vec++; if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) begin
         n_err++; $display("FAIL reset_busy: got %b/%b expected 1", bus0.busy, bus1.busy); end
      n_vec++; if (bus0.rd_par_err !== 1'b0 || bus1.rd_par_err !== 1'b0) begin
         n_err++; $display("FAIL reset_par_err: got %b/%b expected 0", bus0.rd_par_err, bus1.rd_par_err); end
      rst = 0;
      rd_en = 1;
      cnt = 0;
      while (bus0.busy === 1'b1 && cnt < 40) begin
         cnt++;
         rd_addr = AW'($urandom_range(0, DEPTH - 1));
         cycle();
         n_vec++; if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0) begin
            n_err++; $display("FAIL busy_no_valid: got %b/%b expected 0", bus0.rd_valid, bus1.rd_valid); end
      end
      n_vec++; if (cnt != 16) begin
         n_err++; $display("FAIL busy_length: got %0d expected 16", cnt); end
      n_vec++; if (bus1.busy !== 1'b0) begin
         n_err++; $display("FAIL busy1_drop: got %b expected 0", bus1.busy); end
      rd_addr = 5;
      cycle();
      n_vec++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'h0) begin
         n_err++; $display("FAIL first_read: got v=%b d=%h expected v=1 d=00000000", bus0.rd_valid, bus0.rd_data); end
      rd_en = 0;
      cycle();
      n_vec++; if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== exp_d0) begin
         n_err++; $display("FAIL idle_after_read: got v=%b d=%h expected v=0 d=%h", bus0.rd_valid, bus0.rd_data, exp_d0); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] tbl [4];
      tbl[0] = 32'hA0A0A0A0; tbl[1] = 32'h41414140; tbl[2] = 32'hE1E1E1E0; tbl[3] = 32'h82828280;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1; wr_addr = AW'(i + 1); wr_data = tbl[i]; wr_be = 4'hF;
         cycle();
      end
      wr_en = 0;
      for (int i = 0; i < 4; i++) begin
         rd_en = 1; rd_addr = AW'(i + 1);
         cycle();
         n_vec++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== tbl[i] || bus1.rd_data !== tbl[i]) begin
            n_err++; $display("FAIL b2b_read addr %0d: got v=%b d=%h/%h expected v=1 d=%h",
                              i + 1, bus0.rd_valid, bus0.rd_data, bus1.rd_data, tbl[i]); end
      end
      rd_en = 0;
      cycle();
      n_vec++; if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== tbl[3]) begin
         n_err++; $display("FAIL b2b_hold: got v=%b d=%h expected v=0 d=%h", bus0.rd_valid, bus0.rd_data, tbl[3]); end
   endtask

   task automatic test_byte_enable();
      idle_inputs();
      wr_en = 1; wr_addr = 3; wr_data = 32'h11223344; wr_be = 4'hF; cycle();
      wr_data = 32'hAABBCCDD; wr_be = 4'b0101; cycle();
      wr_en = 0; wr_be = 4'h0; rd_en = 1; rd_addr = 3; cycle();
      n_vec++; if (bus0.rd_data !== 32'h11BB33DD || bus0.rd_valid !== 1'b1) begin
         n_err++; $display("FAIL byte_enable: got v=%b d=%h expected v=1 d=11bb33dd", bus0.rd_valid, bus0.rd_data); end
      // Write with no byte enabled leaves the word untouched
      wr_en = 1; wr_data = 32'hFFFFFFFF; wr_be = 4'h0; rd_en = 0; cycle();
      wr_en = 0; rd_en = 1; cycle();
      n_vec++; if (bus1.rd_data !== 32'h11BB33DD) begin
         n_err++; $display("FAIL be_zero_noop: got %h expected 11bb33dd", bus1.rd_data); end
      rd_en = 0; cycle();
   endtask

   task automatic test_collision();
      idle_inputs();
      wr_en = 1; wr_addr = 7; wr_data = 32'h01020304; wr_be = 4'hF; cycle();
      wr_data = 32'hFFFF0000; wr_be = 4'b1100; rd_en = 1; rd_addr = 7; cycle();
      n_vec++; if (bus0.rd_data !== 32'h01020304) begin
         n_err++; $display("FAIL rdw_old: got %h expected 01020304", bus0.rd_data); end
      n_vec++; if (bus1.rd_data !== 32'hFFFF0304) begin
         n_err++; $display("FAIL rdw_new: got %h expected ffff0304", bus1.rd_data); end
      wr_en = 0; cycle();
      n_vec++; if (bus0.rd_data !== 32'hFFFF0304 || bus1.rd_data !== 32'hFFFF0304) begin
         n_err++; $display("FAIL rdw_after: got %h/%h expected ffff0304", bus0.rd_data, bus1.rd_data); end
      rd_en = 0; cycle();
   endtask

   task automatic test_reset_mid_sweep();
      int cnt;
      idle_inputs();
      rst = 1; cycle(); cycle();
      rst = 0; repeat (5) cycle();
      rst = 1; cycle();
      rst = 0;
      wr_en = 1; wr_addr = 2; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
      cnt = 0;
      while (bus0.busy === 1'b1 && cnt < 40) begin
         cnt++;
         cycle();
      end
      n_vec++; if (cnt != 16) begin
         n_err++; $display("FAIL restart_busy_length: got %0d expected 16", cnt); end
      wr_en = 0; rd_en = 1; rd_addr = 2; cycle();
      n_vec++; if (bus0.rd_data !== 32'h0 || bus0.rd_valid !== 1'b1) begin
         n_err++; $display("FAIL write_while_busy: got v=%b d=%h expected v=1 d=00000000", bus0.rd_valid, bus0.rd_data); end
      rd_en = 0; cycle();
   endtask

   task automatic test_parity();
      idle_inputs();
      wr_en = 1; wr_addr = 2; wr_data = 32'h12345678; wr_be = 4'hF; wr_par_flip = 1; cycle();
      wr_en = 0; wr_par_flip = 0; rd_en = 1; rd_addr = 2; cycle();
      n_vec++; if (bus0.rd_par_err !== PAR_EN || bus1.rd_par_err !== PAR_EN || bus0.rd_valid !== 1'b1) begin
         n_err++; $display("FAIL parity_flip: got %b/%b expected %b", bus0.rd_par_err, bus1.rd_par_err, PAR_EN); end
      rd_en = 0; cycle();
      n_vec++; if (bus0.rd_par_err !== 1'b0) begin
         n_err++; $display("FAIL parity_idle: got %b expected 0", bus0.rd_par_err); end
      wr_en = 1; cycle();
      wr_en = 0; rd_en = 1; cycle();
      n_vec++; if (bus0.rd_par_err !== 1'b0 || bus1.rd_par_err !== 1'b0) begin
         n_err++; $display("FAIL parity_clean: got %b/%b expected 0", bus0.rd_par_err, bus1.rd_par_err); end
      rd_en = 0; cycle();
   endtask

   task automatic test_random();
      idle_inputs();
      for (int n = 0; n < 400; n++) begin
         wr_en       = $urandom_range(0, 1);
         wr_addr     = AW'($urandom_range(0, DEPTH - 1));
         wr_data     = $urandom();
         wr_be       = 4'($urandom_range(0, 15));
         wr_par_flip = ($urandom_range(0, 7) == 0);
         rd_en       = ($urandom_range(0, 3) != 0);
         rd_addr     = ($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
         cycle();
         n_vec++; if (bus0.rd_valid !== exp_v || bus1.rd_valid !== exp_v) begin
            n_err++; $display("FAIL rand_valid #%0d: got %b/%b expected %b", n, bus0.rd_valid, bus1.rd_valid, exp_v); end
         n_vec++; if (bus0.rd_data !== exp_d0) begin
            n_err++; $display("FAIL rand_data_old #%0d: got %h expected %h", n, bus0.rd_data, exp_d0); end
         n_vec++; if (bus1.rd_data !== exp_d1) begin
            n_err++; $display("FAIL rand_data_new #%0d: got %h expected %h", n, bus1.rd_data, exp_d1); end
         n_vec++; if (bus0.rd_par_err !== (PAR_EN & exp_e0) || bus1.rd_par_err !== (PAR_EN & exp_e1)) begin
            n_err++; $display("FAIL rand_par_err #%0d: got %b/%b expected %b/%b", n,
                              bus0.rd_par_err, bus1.rd_par_err, PAR_EN & exp_e0, PAR_EN & exp_e1); end
         n_vec++; if (bus0.busy !== exp_busy) begin
            n_err++; $display("FAIL rand_busy #%0d: got %b expected %b", n, bus0.busy, exp_busy); end
      end
      idle_inputs();
      cycle();
   endtask

   initial begin
      for (int a = 0; a < int'(DEPTH); a++) begin
         m_mem[a] = '0;
         m_bad[a] = 0;
      end
      rst = 1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_byte_enable();
      test_collision();
      test_reset_mid_sweep();
      test_parity();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete within 200000 time units");
      $fatal(1, "timeout");
   end
endmodule
